// File: rtl/rx_symbol_decoder_if.sv
// Byte-in / decoded-out bundle for rx_symbol_decoder.
// master drives the joined receive byte; slave is the decoder.
interface rx_symbol_decoder_if;
  logic [7:0] rxDATA;
  logic       rxVLD;
  logic [3:0] outCTRL;
  logic [7:0] outDATA;
  logic       outVLD;
  logic [7:0] tlpDATA;
  logic       tlpVLD;
  logic       tlpSOP;
  logic       tlpEOP;
  logic       tlpKIND;
  logic       tlpERR;
  logic       skpDET;
  logic       protoERR;
  logic [7:0] skpCNT;

  modport master (
    output rxDATA, rxVLD,
    input  outCTRL, outDATA, outVLD, tlpDATA, tlpVLD, tlpSOP, tlpEOP,
           tlpKIND, tlpERR, skpDET, protoERR, skpCNT
  );
  modport slave (
    input  rxDATA, rxVLD,
    output outCTRL, outDATA, outVLD, tlpDATA, tlpVLD, tlpSOP, tlpEOP,
           tlpKIND, tlpERR, skpDET, protoERR, skpCNT
  );
endinterface

// File: rtl/rx_symbol_decoder.sv
// Receive symbol classifier and TLP/DLLP framer with one-entry payload buffer.
// Optional RX_SKP_COUNT_EN builds a saturating SKP ordered-set counter on skpCNT.
module rx_symbol_decoder #(
  parameter logic [7:0] COM = 8'hBC,
  parameter logic [7:0] PAD = 8'hF7,
  parameter logic [7:0] SKP = 8'h1C,
  parameter logic [7:0] STP = 8'hFB,
  parameter logic [7:0] SDP = 8'h5C,
  parameter logic [7:0] END = 8'hFD,
  parameter logic [7:0] EDB = 8'hFE,
  parameter logic [7:0] FTS = 8'h3C,
  parameter logic [7:0] IDL = 8'h7C,
  parameter int         MAX_LEN = 32
) (
  input logic                CLK,
  input logic                reset,
  rx_symbol_decoder_if.slave bus
);
  localparam logic [3:0] C_DATA = 4'd0, C_COM = 4'd1, C_PAD = 4'd2, C_SKP = 4'd3,
                         C_STP  = 4'd4, C_SDP = 4'd5, C_END = 4'd6, C_EDB = 4'd7,
                         C_FTS  = 4'd8, C_IDL = 4'd9;

  typedef enum logic [2:0] {S_IDLE, S_COM, S_TLP, S_DLLP, S_DROP} state_t;

  state_t     state, state_n;
  logic [7:0] hold_data, hold_data_n;
  logic       hold_vld, hold_vld_n;
  logic       sop_pend, sop_pend_n;
  logic       kind, kind_n;
  logic [7:0] len, len_n;
  logic [3:0] code, ctrl_n;
  logic       rel, rel_eop, rel_err, skp_n, perr_n;
  logic       is_open, is_close;

  function automatic logic [3:0] classify(input logic [7:0] b);
    if (b == COM) return C_COM;
    if (b == PAD) return C_PAD;
    if (b == SKP) return C_SKP;
    if (b == STP) return C_STP;
    if (b == SDP) return C_SDP;
    if (b == END) return C_END;
    if (b == EDB) return C_EDB;
    if (b == FTS) return C_FTS;
    if (b == IDL) return C_IDL;
    return C_DATA;
  endfunction

  always_comb begin
    state_n     = state;
    hold_data_n = hold_data;
    hold_vld_n  = hold_vld;
    sop_pend_n  = sop_pend;
    kind_n      = kind;
    len_n       = len;
    rel         = 1'b0;
    rel_eop     = 1'b0;
    rel_err     = 1'b0;
    skp_n       = 1'b0;
    perr_n      = 1'b0;
    code        = classify(bus.rxDATA);
    ctrl_n      = code;
    is_open     = (code == C_STP) || (code == C_SDP);
    is_close    = (code == C_END) || (code == C_EDB);
    if (bus.rxVLD) begin
      if ((state == S_TLP || state == S_DLLP) && !is_open && !is_close) ctrl_n = C_DATA;
      case (state)
        S_IDLE, S_COM: begin
          if (is_open) begin
            state_n = S_TLP;
          end else if (code == C_COM) begin
            state_n = S_COM;
          end else if (state == S_COM && code == C_SKP) begin
            skp_n   = 1'b1;
            state_n = S_IDLE;
          end else begin
            perr_n  = (state == S_IDLE) && is_close;
            state_n = S_IDLE;
          end
        end
        S_TLP, S_DLLP: begin
          if (is_open || is_close) begin
            // Held byte closes the frame; an empty frame or a restart is a framing error.
            rel        = hold_vld;
            rel_eop    = 1'b1;
            rel_err    = (code != C_END);
            perr_n     = !hold_vld || is_open;
            hold_vld_n = 1'b0;
            state_n    = S_IDLE;
          end else if (len == 8'(MAX_LEN)) begin
            rel        = hold_vld;
            rel_eop    = 1'b1;
            rel_err    = 1'b1;
            hold_vld_n = 1'b0;
            state_n    = S_DROP;
          end else begin
            rel         = hold_vld;
            hold_vld_n  = 1'b1;
            hold_data_n = bus.rxDATA;
            len_n       = len + 8'd1;
          end
        end
        S_DROP:  if (is_close) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
      if (rel) sop_pend_n = 1'b0;
      if (is_open && state != S_DROP) begin
        state_n    = (code == C_SDP) ? S_DLLP : S_TLP;
        kind_n     = (code == C_SDP);
        len_n      = 8'd0;
        sop_pend_n = 1'b1;
        hold_vld_n = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      hold_data    <= '0;
      hold_vld     <= 1'b0;
      sop_pend     <= 1'b0;
      kind         <= 1'b0;
      len          <= '0;
      bus.outCTRL  <= '0;
      bus.outDATA  <= '0;
      bus.outVLD   <= 1'b0;
      bus.tlpDATA  <= '0;
      bus.tlpVLD   <= 1'b0;
      bus.tlpSOP   <= 1'b0;
      bus.tlpEOP   <= 1'b0;
      bus.tlpKIND  <= 1'b0;
      bus.tlpERR   <= 1'b0;
      bus.skpDET   <= 1'b0;
      bus.protoERR <= 1'b0;
    end else begin
      hold_data    <= hold_data_n;
      hold_vld     <= hold_vld_n;
      sop_pend     <= sop_pend_n;
      kind         <= kind_n;
      len          <= len_n;
      bus.outVLD   <= bus.rxVLD;
      if (bus.rxVLD) begin
        bus.outCTRL <= ctrl_n;
        bus.outDATA <= bus.rxDATA;
      end
      // tlpKIND comes from the closing frame even when a new frame opens this cycle.
      bus.tlpVLD   <= rel;
      bus.tlpSOP   <= rel & sop_pend;
      bus.tlpEOP   <= rel & rel_eop;
      bus.tlpERR   <= rel & rel_err;
      if (rel) begin
        bus.tlpDATA <= hold_data;
        bus.tlpKIND <= kind;
      end
      bus.skpDET   <= skp_n;
      bus.protoERR <= perr_n;
    end
  end

`ifdef RX_SKP_COUNT_EN
  logic [7:0] skp_cnt;
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)                         skp_cnt <= '0;
    else if (skp_n && skp_cnt != 8'hFF) skp_cnt <= skp_cnt + 8'd1;
  end
  assign bus.skpCNT = skp_cnt;
`else
  assign bus.skpCNT = 8'h00;
`endif
endmodule
